// File: rtl/ifetch_queue.sv
// Instruction fetch front end: credit-limited in-order word fetch, DEPTH-entry
// prefetch queue with PC/fault tagging, and valid/ready delivery to decode.
module ifetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_rdy,
    input  logic        i_imem_rsp,
    input  logic [31:0] i_imem_data,
    input  logic        i_imem_err,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_inst_valid,
    output logic [31:0] o_inst,
    output logic [31:0] o_inst_pc,
    output logic        o_inst_excp_en,
    output logic [31:0] o_inst_excp,
    input  logic        i_inst_ready
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [31:0] NOP            = 32'h0000_0013;
    localparam logic [31:0] CAUSE_MISALIGN = 32'd0;
    localparam logic [31:0] CAUSE_ACCESS   = 32'd1;
    localparam logic [31:0] CAUSE_NONE     = 32'd63;

    typedef enum logic {RUN, HALT} mode_t;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] pc;
        logic        excp_en;
        logic        access;   // 1: access fault, 0: misaligned target
    } entry_t;

    entry_t        r_q [DEPTH];
    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_wr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_infl;
    logic [CW-1:0] r_drop;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_rsp_pc;
    mode_t         r_mode;

    logic          w_req;
    logic          w_hs;
    logic          w_valid;
    logic          w_pop;
    logic          w_push;
    logic          w_rsp_drop;
    logic [CW:0]   w_credit;
    logic [CW-1:0] w_infl_nxt;
    entry_t        w_head;

    // Requests are credit-limited so every response has a queue slot waiting.
    assign w_credit   = (CW+1)'(r_count) + (CW+1)'(r_infl);
    assign w_req      = (r_mode == RUN) && !i_rst && !i_redirect && (w_credit < (CW+1)'(DEPTH));
    assign w_hs       = w_req && i_imem_rdy;
    assign w_valid    = (r_count != '0) && !i_redirect && !i_rst;
    assign w_pop      = w_valid && i_inst_ready;
    assign w_rsp_drop = (r_drop != '0);
    assign w_push     = i_imem_rsp && !w_rsp_drop && !i_redirect;
    assign w_infl_nxt = r_infl + CW'(w_hs) - CW'(i_imem_rsp);
    assign w_head     = r_q[r_rd];

    assign o_imem_req     = w_req;
    assign o_imem_addr    = r_fetch_pc;
    assign o_inst_valid   = w_valid;
    assign o_inst         = w_valid ? w_head.data : NOP;
    assign o_inst_pc      = w_valid ? w_head.pc : 32'd0;
    assign o_inst_excp_en = w_valid && w_head.excp_en;

    always_comb begin
        o_inst_excp = CAUSE_NONE;
        if (w_valid && w_head.excp_en)
            o_inst_excp = w_head.access ? CAUSE_ACCESS : CAUSE_MISALIGN;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd       <= '0;
            r_wr       <= '0;
            r_count    <= '0;
            r_infl     <= '0;
            r_drop     <= '0;
            r_fetch_pc <= RESET_PC;
            r_rsp_pc   <= RESET_PC;
            r_mode     <= RUN;
        end else begin
            r_infl <= w_infl_nxt;
            if (i_redirect) begin
                r_fetch_pc <= {i_redirect_pc[31:2], 2'b00};
                r_rsp_pc   <= {i_redirect_pc[31:2], 2'b00};
                // Every response still outstanding after this edge belongs to the old stream.
                r_drop     <= r_infl - CW'(i_imem_rsp);
                r_rd       <= '0;
                if (i_redirect_pc[1:0] != 2'b00) begin
                    r_q[0]  <= '{data: NOP, pc: i_redirect_pc, excp_en: 1'b1, access: 1'b0};
                    r_wr    <= AW'(1);
                    r_count <= CW'(1);
                    r_mode  <= HALT;
                end else begin
                    r_wr    <= '0;
                    r_count <= '0;
                    r_mode  <= RUN;
                end
            end else begin
                if (w_hs)
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                if (i_imem_rsp && w_rsp_drop)
                    r_drop <= r_drop - CW'(1);
                if (w_push) begin
                    r_q[r_wr] <= '{data: i_imem_data, pc: r_rsp_pc, excp_en: i_imem_err, access: 1'b1};
                    r_wr      <= r_wr + AW'(1);
                    r_rsp_pc  <= r_rsp_pc + 32'd4;
                    if (i_imem_err)
                        r_mode <= HALT;
                end
                if (w_pop)
                    r_rd <= r_rd + AW'(1);
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    // The credit rule must make a push into a full queue impossible.
    always_ff @(posedge i_clk) begin
        if (!i_rst && w_push)
            assert (r_count != CW'(DEPTH));
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: bench-side in-order memory model with
// optional hold and fault injection, hand-computed expectations per cycle.
module tb_ifetch_queue;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_rdy;
    logic        i_imem_rsp;
    logic [31:0] i_imem_data;
    logic        i_imem_err;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        o_inst_valid;
    logic [31:0] o_inst;
    logic [31:0] o_inst_pc;
    logic        o_inst_excp_en;
    logic [31:0] o_inst_excp;
    logic        i_inst_ready;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          hs_cnt = 0;
    logic [31:0] mq [$];
    logic        mem_hold = 1'b0;
    logic        err_on = 1'b0;
    logic [31:0] err_addr = 32'h8;

    ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .i_clk          (clk),
        .i_rst          (i_rst),
        .o_imem_req     (o_imem_req),
        .o_imem_addr    (o_imem_addr),
        .i_imem_rdy     (i_imem_rdy),
        .i_imem_rsp     (i_imem_rsp),
        .i_imem_data    (i_imem_data),
        .i_imem_err     (i_imem_err),
        .i_redirect     (i_redirect),
        .i_redirect_pc  (i_redirect_pc),
        .o_inst_valid   (o_inst_valid),
        .o_inst         (o_inst),
        .o_inst_pc      (o_inst_pc),
        .o_inst_excp_en (o_inst_excp_en),
        .o_inst_excp    (o_inst_excp),
        .i_inst_ready   (i_inst_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_head(input string tag, input logic v, input logic [31:0] inst,
                            input logic [31:0] pc, input logic en, input logic [31:0] ex);
        chk($sformatf("%s.valid", tag), 32'(o_inst_valid), 32'(v));
        chk($sformatf("%s.inst", tag), o_inst, inst);
        chk($sformatf("%s.pc", tag), o_inst_pc, pc);
        chk($sformatf("%s.excp_en", tag), 32'(o_inst_excp_en), 32'(en));
        chk($sformatf("%s.excp", tag), o_inst_excp, ex);
    endtask

    task automatic settle();
        #1;
    endtask

    // One clock: record the handshake, then present the next in-order response.
    task automatic cycle();
        logic        hs;
        logic        rst_s;
        logic [31:0] a;
        #1;
        hs    = o_imem_req && i_imem_rdy;
        a     = o_imem_addr;
        rst_s = i_rst;
        if (hs) hs_cnt++;
        @(posedge clk);
        #1;
        if (rst_s) mq.delete();
        else if (hs) mq.push_back(a);
        if (!rst_s && !mem_hold && mq.size() > 0) begin
            i_imem_rsp  = 1'b1;
            i_imem_data = mq[0];
            i_imem_err  = err_on && (mq[0] == err_addr);
            void'(mq.pop_front());
        end else begin
            i_imem_rsp  = 1'b0;
            i_imem_data = 32'd0;
            i_imem_err  = 1'b0;
        end
    endtask

    task automatic do_reset();
        i_rst      = 1'b1;
        i_redirect = 1'b0;
        mem_hold   = 1'b0;
        err_on     = 1'b0;
        cycle();
        cycle();
        i_rst  = 1'b0;
        hs_cnt = 0;
    endtask

    initial begin
        i_rst         = 1'b1;
        i_imem_rdy    = 1'b1;
        i_imem_rsp    = 1'b0;
        i_imem_data   = 32'd0;
        i_imem_err    = 1'b0;
        i_redirect    = 1'b0;
        i_redirect_pc = 32'd0;
        i_inst_ready  = 1'b1;

        // Reset state
        cycle();
        cycle();
        settle();
        chk("rst.req", 32'(o_imem_req), 32'd0);
        chk_head("rst", 1'b0, 32'h13, 32'd0, 1'b0, 32'd63);
        cycle();
        i_rst = 1'b0;

        // Streaming: word = address, one per cycle from cycle 3
        for (int k = 1; k <= 8; k++) begin
            settle();
            if (k == 1) begin
                chk("stream.req1", 32'(o_imem_req), 32'd1);
                chk("stream.addr1", o_imem_addr, 32'd0);
            end
            if (k < 3) chk($sformatf("stream.valid%0d", k), 32'(o_inst_valid), 32'd0);
            else chk_head($sformatf("stream%0d", k), 1'b1, 32'(4 * (k - 3)), 32'(4 * (k - 3)), 1'b0, 32'd63);
            cycle();
        end

        // Backpressure: decoder stalled for 10 cycles
        i_inst_ready = 1'b0;
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            settle();
            if (k == 10) begin
                chk("bp.req_stalled", 32'(o_imem_req), 32'd0);
                chk_head("bp.stalled", 1'b1, 32'd0, 32'd0, 1'b0, 32'd63);
            end
            cycle();
        end
        chk("bp.handshakes", 32'(hs_cnt), 32'd4);
        i_inst_ready = 1'b1;
        for (int k = 0; k <= 5; k++) begin
            settle();
            if (k == 0) chk("bp.req_at_release", 32'(o_imem_req), 32'd0);
            if (k == 1) begin
                chk("bp.req_resume", 32'(o_imem_req), 32'd1);
                chk("bp.addr_resume", o_imem_addr, 32'd16);
            end
            chk_head($sformatf("bp.drain%0d", k), 1'b1, 32'(4 * k), 32'(4 * k), 1'b0, 32'd63);
            cycle();
        end

        // Redirect with three requests in flight
        do_reset();
        mem_hold = 1'b1;
        cycle();
        cycle();
        cycle();
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h100;
        settle();
        chk("rd3.req_during", 32'(o_imem_req), 32'd0);
        chk("rd3.valid_during", 32'(o_inst_valid), 32'd0);
        cycle();
        i_redirect = 1'b0;
        mem_hold   = 1'b0;
        settle();
        chk("rd3.req_new", 32'(o_imem_req), 32'd1);
        chk("rd3.addr_new", o_imem_addr, 32'h100);
        cycle();
        for (int k = 6; k <= 9; k++) begin
            settle();
            chk($sformatf("rd3.no_stale%0d", k), 32'(o_inst_valid), 32'd0);
            cycle();
        end
        settle();
        chk_head("rd3.first", 1'b1, 32'h100, 32'h100, 1'b0, 32'd63);
        cycle();

        // Redirect, response and pop all in the same cycle
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h300;
        settle();
        chk("simul.valid_during", 32'(o_inst_valid), 32'd0);
        cycle();
        i_redirect = 1'b0;
        settle();
        chk("simul.empty_next", 32'(o_inst_valid), 32'd0);
        chk("simul.req_new", 32'(o_imem_req), 32'd1);
        chk("simul.addr_new", o_imem_addr, 32'h300);
        cycle();
        settle();
        chk("simul.no_stale", 32'(o_inst_valid), 32'd0);
        cycle();
        settle();
        chk_head("simul.first", 1'b1, 32'h300, 32'h300, 1'b0, 32'd63);
        cycle();

        // Misaligned redirect: single fault entry, fetch halted
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h102;
        cycle();
        i_redirect   = 1'b0;
        i_inst_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk($sformatf("mis.req%0d", k), 32'(o_imem_req), 32'd0);
            chk_head($sformatf("mis.head%0d", k), 1'b1, 32'h13, 32'h102, 1'b1, 32'd0);
            cycle();
        end
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h200;
        i_inst_ready  = 1'b1;
        settle();
        chk("mis.valid_redirect", 32'(o_inst_valid), 32'd0);
        cycle();
        i_redirect = 1'b0;
        settle();
        chk("mis.req_resume", 32'(o_imem_req), 32'd1);
        chk("mis.addr_resume", o_imem_addr, 32'h200);
        cycle();
        cycle();
        settle();
        chk_head("mis.resumed", 1'b1, 32'h200, 32'h200, 1'b0, 32'd63);
        cycle();

        // Access fault on the response for address 8
        do_reset();
        err_on   = 1'b1;
        err_addr = 32'h8;
        cycle();
        cycle();
        settle();
        chk_head("err.w0", 1'b1, 32'h0, 32'h0, 1'b0, 32'd63);
        cycle();
        settle();
        chk_head("err.w4", 1'b1, 32'h4, 32'h4, 1'b0, 32'd63);
        cycle();
        settle();
        chk_head("err.fault", 1'b1, 32'h8, 32'h8, 1'b1, 32'd1);
        chk("err.req_halt", 32'(o_imem_req), 32'd0);
        cycle();
        settle();
        chk_head("err.tail", 1'b1, 32'hC, 32'hC, 1'b0, 32'd63);
        chk("err.req_halt2", 32'(o_imem_req), 32'd0);
        cycle();
        for (int k = 0; k < 3; k++) begin
            settle();
            chk($sformatf("err.idle_valid%0d", k), 32'(o_inst_valid), 32'd0);
            chk($sformatf("err.idle_req%0d", k), 32'(o_imem_req), 32'd0);
            cycle();
        end
        err_on = 1'b0;

        // Reset in the middle of a stream
        do_reset();
        for (int k = 0; k < 5; k++) cycle();
        i_rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            settle();
            chk($sformatf("mrst.req%0d", k), 32'(o_imem_req), 32'd0);
            chk_head($sformatf("mrst.head%0d", k), 1'b0, 32'h13, 32'd0, 1'b0, 32'd63);
            cycle();
        end
        i_rst = 1'b0;
        settle();
        chk("mrst.req_restart", 32'(o_imem_req), 32'd1);
        chk("mrst.addr_restart", o_imem_addr, 32'd0);
        cycle();
        cycle();
        settle();
        chk_head("mrst.first", 1'b1, 32'd0, 32'd0, 1'b0, 32'd63);
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
